// File: rtl/cache_arbiter_pkg.sv
// cache_arbiter_pkg
//   Shared types for the L1 -> L2 cache port arbiter.
//   arb_state_t : arbiter FSM states.
//   arb_prio_t  : requester favoured on a tie when round-robin
//                 arbitration is built (ARB_ROUND_ROBIN_EN).
package cache_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    PRIO_D = 1'b0,
    PRIO_I = 1'b1
  } arb_prio_t;

endpackage

// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Shares one L2 cache port between the L1 instruction cache (read-only)
//   and the L1 data cache (read/write). Whole-line transfers, one
//   outstanding transaction at a time.
//
//   Optional build macro: ARB_ROUND_ROBIN_EN
//     undefined : D-cache wins every simultaneous request.
//     defined   : a 1-bit pointer alternates the winner of simultaneous
//                 requests; single requests are granted immediately.
//
//   Ports
//     clk, rst_n           clock (rising edge), async active-low reset
//     i_read, i_address    I-cache line read request / address
//     i_rdata, i_resp      line data to I-cache, one-cycle completion
//     d_read, d_write      D-cache line read / writeback request
//     d_address, d_wdata   D-cache address / writeback data
//     d_rdata, d_resp      line data to D-cache, one-cycle completion
//     l2_address/_wdata    to l2_cache mem_address / mem_wdata
//     l2_read, l2_write    to l2_cache mem_read / mem_write
//     l2_resp, l2_rdata    from l2_cache mem_resp / mem_rdata
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  output logic              l2_read,
  output logic              l2_write,
  input  logic              l2_resp,
  input  logic [LINE_W-1:0] l2_rdata
);

  arb_state_t state, state_nxt;
  logic       d_req;
  logic       tie_to_d;

`ifdef ARB_ROUND_ROBIN_EN
  // Names the requester that wins the next tie; it flips to the other
  // requester whenever a transaction completes.
  arb_prio_t  prio, prio_nxt;
  assign tie_to_d = (prio == PRIO_D);
`else
  assign tie_to_d = 1'b1;
`endif

  assign d_req = d_read | d_write;

  // Read data is broadcast; the resp pulse is the only qualifier.
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

  // State register (and tie pointer when built)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
      prio  <= PRIO_D;
`endif
    end else begin
      state <= state_nxt;
`ifdef ARB_ROUND_ROBIN_EN
      prio  <= prio_nxt;
`endif
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
`ifdef ARB_ROUND_ROBIN_EN
    prio_nxt  = prio;
`endif
    unique case (state)
      IDLE: begin
        if (d_req && (!i_read || tie_to_d)) state_nxt = SERVE_D;
        else if (i_read)                    state_nxt = SERVE_I;
      end
      SERVE_I: begin
        if (l2_resp) begin
          state_nxt = RELEASE;
`ifdef ARB_ROUND_ROBIN_EN
          prio_nxt  = PRIO_D;
`endif
        end
      end
      SERVE_D: begin
        if (l2_resp) begin
          state_nxt = RELEASE;
`ifdef ARB_ROUND_ROBIN_EN
          prio_nxt  = PRIO_I;
`endif
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: L2 strobes follow the registered state, so they drop
  // as soon as reset forces IDLE, without waiting for a clock edge.
  always_comb begin
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_address = '0;
    l2_wdata   = '0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    unique case (state)
      SERVE_I: begin
        l2_read    = 1'b1;
        l2_address = i_address;
        i_resp     = l2_resp;
      end
      SERVE_D: begin
        l2_read    = d_read;
        l2_write   = d_write;
        l2_address = d_address;
        l2_wdata   = d_wdata;
        d_resp     = l2_resp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter
//   Directed scenarios followed by randomized L1/L2 traffic, every cycle
//   compared against a transaction-level ownership model of the port.
module tb_cache_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read, d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic [ADDR_W-1:0] l2_address;
  logic [LINE_W-1:0] l2_wdata;
  logic              l2_read, l2_write;
  logic              l2_resp;
  logic [LINE_W-1:0] l2_rdata;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the L2 port, whether the port is in its
  // one-cycle cool-down after a completion, and who wins a tie.
  int owner    = 0;    // 0 none, 1 I-cache, 2 D-cache
  bit cooldown = 1'b0;
  bit tie_d    = 1'b1;
  bit i_seen, d_seen;  // resp observed last cycle (L1 drops its request)
  int grants_d = 0;
  int grants_i = 0;

  always #5 clk = ~clk;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_address(l2_address), .l2_wdata(l2_wdata), .l2_read(l2_read),
    .l2_write(l2_write), .l2_resp(l2_resp), .l2_rdata(l2_rdata)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rnd_line();
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Compare the current cycle against the model, then advance the model
  // to what the coming rising edge should do.
  task automatic compare_and_advance();
    logic              e_read, e_write, e_iresp, e_dresp;
    logic [ADDR_W-1:0] e_addr;
    logic [LINE_W-1:0] e_wdata;
    e_read = 1'b0; e_write = 1'b0; e_iresp = 1'b0; e_dresp = 1'b0;
    e_addr = '0;   e_wdata = '0;
    if (rst_n && owner == 1) begin
      e_read = 1'b1; e_addr = i_address; e_iresp = l2_resp;
    end else if (rst_n && owner == 2) begin
      e_read = d_read; e_write = d_write; e_addr = d_address;
      e_wdata = d_wdata; e_dresp = l2_resp;
    end
    check("l2_read",    256'(l2_read),    256'(e_read));
    check("l2_write",   256'(l2_write),   256'(e_write));
    check("l2_address", 256'(l2_address), 256'(e_addr));
    check("l2_wdata",   l2_wdata,         e_wdata);
    check("i_resp",     256'(i_resp),     256'(e_iresp));
    check("d_resp",     256'(d_resp),     256'(e_dresp));
    check("i_rdata",    i_rdata,          l2_rdata);
    check("d_rdata",    d_rdata,          l2_rdata);
    i_seen = i_resp;
    d_seen = d_resp;

    if (!rst_n) begin
      owner = 0; cooldown = 1'b0; tie_d = 1'b1;
    end else if (cooldown) begin
      cooldown = 1'b0;
    end else if (owner == 0) begin
      if ((d_read || d_write) && (!i_read || tie_d)) begin
        owner = 2; grants_d++;
      end else if (i_read) begin
        owner = 1; grants_i++;
      end
    end else if (l2_resp) begin
`ifdef ARB_ROUND_ROBIN_EN
      tie_d = (owner == 1);
`endif
      owner    = 0;
      cooldown = 1'b1;
    end
  endtask

  // Caller drives inputs at posedge+1; this checks at the falling edge and
  // returns at the next posedge+1.
  task automatic tick();
    @(negedge clk);
    compare_and_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random();
    if (i_read && i_seen)                     i_read = 1'b0;
    else if (!i_read && $urandom_range(0, 3) == 0) begin
      i_read    = 1'b1;
      i_address = $urandom & 32'hFFFF_FFE0;
    end else if (i_read && $urandom_range(0, 19) == 0) i_read = 1'b0;

    if ((d_read || d_write) && d_seen) begin
      d_read = 1'b0; d_write = 1'b0;
    end else if (!(d_read || d_write) && $urandom_range(0, 3) == 0) begin
      if ($urandom_range(0, 1) == 0) d_read = 1'b1; else d_write = 1'b1;
      d_address = $urandom & 32'hFFFF_FFE0;
      d_wdata   = rnd_line();
    end
    l2_resp  = ($urandom_range(0, 2) == 0);
    l2_rdata = rnd_line();
  endtask

  initial begin
    logic [LINE_W-1:0] a5_line;
    int                gd0, gi0, order_ok;
    a5_line = {(LINE_W / 8){8'hA5}};

    rst_n = 1'b0; i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
    d_address = '0; d_wdata = '0; l2_resp = 1'b0; l2_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    tick();                       // reset state: all outputs zero
    rst_n = 1'b1;

    // I-only read, L2 answers in the third serve cycle
    i_read = 1'b1; i_address = 32'h0000_0100; l2_rdata = a5_line;
    tick();                       // IDLE sees the request
    tick(); tick();               // serve cycles 1-2
    l2_resp = 1'b1;
    tick();                       // serve cycle 3: i_resp
    i_read = 1'b0; l2_resp = 1'b0;
    tick(); tick();               // release, idle

    // D writeback
    d_write = 1'b1; d_address = 32'h0000_2000;
    d_wdata = {8{32'h1234_5678}};
    tick(); tick();
    l2_resp = 1'b1;
    tick();
    d_write = 1'b0; l2_resp = 1'b0;
    tick(); tick();

    // Simultaneous requests: D must own the port first
    gd0 = grants_d; gi0 = grants_i;
    i_read = 1'b1; i_address = 32'h0000_0400;
    d_read = 1'b1; d_address = 32'h0000_0800;
    tick();
    check("tie_first_grant_d", 256'(grants_d - gd0), 256'(1));
    l2_resp = 1'b1;
    tick();
    d_read = 1'b0; l2_resp = 1'b0;
    tick(); tick();               // release, idle grants I
    l2_resp = 1'b1;
    tick();
    order_ok = grants_i - gi0;
    check("tie_second_grant_i", 256'(order_ok), 256'(1));
    i_read = 1'b0; l2_resp = 1'b0;
    tick(); tick();

    // Early drop: I withdraws one cycle into its transaction
    i_read = 1'b1; i_address = 32'h0000_0C00;
    tick(); tick();
    i_read = 1'b0;
    tick(); tick();
    l2_resp = 1'b1;
    tick();
    l2_resp = 1'b0;
    tick(); tick();

    // Asynchronous reset in the middle of a D writeback
    d_write = 1'b1; d_address = 32'h0000_3000; d_wdata = rnd_line();
    tick();
    #2;
    check("pre_rst_l2_write", 256'(l2_write), 256'(1));
    rst_n = 1'b0;
    #1;
    check("async_rst_l2_write", 256'(l2_write), 256'(0));
    check("async_rst_l2_addr", 256'(l2_address), 256'(0));
    @(posedge clk); #1;
    tick();
    d_write = 1'b0;
    rst_n   = 1'b1;
    tick(); tick();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      drive_random();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
